// File: rtl/seq_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter and the detector benches that consume it.
package seq_pattern_tx_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    // Serial pattern counted by the transmitter and searched for by the detectors.
    localparam logic [2:0] PATTERN = 3'b011;

endpackage

// File: rtl/seq_pattern_tx_pat_monitor.sv
// Counts PATTERN occurrences in the transmitted bit stream, using only bits of the current frame.
module seq_pattern_tx_pat_monitor
    import seq_pattern_tx_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic [CNT_W-1:0] pat_cnt
);

    logic [1:0]       hist_q, hist_d;
    logic [1:0]       hist_vld_q, hist_vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       hist_base;
    logic [1:0]       vld_base;
    logic [CNT_W-1:0] cnt_base;

    // The first bit of a frame arrives together with the clear, so the clear
    // is applied to the base values before the new bit is folded in.
    always_comb begin
        hist_base  = clear ? 2'b00 : hist_q;
        vld_base   = clear ? 2'b00 : hist_vld_q;
        cnt_base   = clear ? '0 : cnt_q;
        hist_d     = hist_base;
        hist_vld_d = vld_base;
        cnt_d      = cnt_base;
        if (bit_valid) begin
            hist_d     = {hist_base[0], bit_in};
            hist_vld_d = {vld_base[0], 1'b1};
            if ((&vld_base) && ({hist_base, bit_in} == PATTERN) &&
                (cnt_base != {CNT_W{1'b1}})) begin
                cnt_d = cnt_base + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q     <= 2'b00;
            hist_vld_q <= 2'b00;
            cnt_q      <= '0;
        end else begin
            hist_q     <= hist_d;
            hist_vld_q <= hist_vld_d;
            cnt_q      <= cnt_d;
        end
    end

    assign pat_cnt = cnt_q;

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: loads a word on start and shifts eff_len bits out MSB-first,
// pulsing done after the last bit and counting 011 occurrences in the sent frame.
module seq_pattern_tx
    import seq_pattern_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN_W = $clog2(WIDTH + 1),
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [LEN_W-1:0] len,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pat_cnt
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             clear_d;
    logic [LEN_W-1:0] eff_len;
    logic [WIDTH-1:0] aligned;

    // Frame bits are left-aligned so the first bit always sits at the MSB.
    assign eff_len = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;
    assign aligned = data_in << (LEN_W'(WIDTH) - eff_len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_SHIFT: state_d = (cnt_q == '0) ? ST_DONE : ST_SHIFT;
            ST_DONE:  state_d = ST_IDLE;
            default: begin
                if (start) begin
                    state_d = (eff_len != '0) ? ST_SHIFT : ST_DONE;
                end
            end
        endcase
    end

    // cnt_q holds the number of bits still to send after the one on out.
    always_comb begin
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        out_d       = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        clear_d     = 1'b0;
        case (state_q)
            ST_SHIFT: begin
                busy_d = 1'b1;
                if (cnt_q != '0) begin
                    out_d       = sh_q[WIDTH-1];
                    out_valid_d = 1'b1;
                    sh_d        = sh_q << 1;
                    cnt_d       = cnt_q - LEN_W'(1);
                end else begin
                    done_d = 1'b1;
                end
            end
            ST_DONE: begin
            end
            default: begin
                if (start) begin
                    clear_d = 1'b1;
                    busy_d  = 1'b1;
                    if (eff_len != '0) begin
                        out_d       = aligned[WIDTH-1];
                        out_valid_d = 1'b1;
                        sh_d        = aligned << 1;
                        cnt_d       = eff_len - LEN_W'(1);
                    end else begin
                        sh_d   = '0;
                        cnt_d  = '0;
                        done_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q        <= '0;
            cnt_q       <= '0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    seq_pattern_tx_pat_monitor #(
        .CNT_W (CNT_W)
    ) u_pat_monitor (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear_d),
        .bit_in    (out_d),
        .bit_valid (out_valid_d),
        .pat_cnt   (pat_cnt)
    );

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: frame timing, clamping, back-to-back frames and reset abort.
module tb_seq_pattern_tx;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] data_in;
    logic [3:0] len;
    logic       out;
    logic       out_valid;
    logic       busy;
    logic       done;
    logic [7:0] pat_cnt;

    int checks = 0;
    int errors = 0;

    seq_pattern_tx #(
        .WIDTH (8),
        .CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .data_in   (data_in),
        .len       (len),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done),
        .pat_cnt   (pat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [7:0] d, input logic [3:0] l);
        start   = s;
        data_in = d;
        len     = l;
    endtask

    // One clock edge, then sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdle(input string tag, input logic [7:0] cnt);
        checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        checkOutput({tag, "_out"}, {31'd0, out}, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
        checkOutput({tag, "_cnt"}, {24'd0, pat_cnt}, {24'd0, cnt});
    endtask

    // Send one frame; bits holds the expected serial bits, first bit at index n-1.
    task automatic runFrame(input string tag, input logic [7:0] d, input logic [3:0] l,
                            input logic [7:0] bits, input int n, input logic [7:0] cnt);
        applyStimulus(1'b1, d, l);
        tick();
        applyStimulus(1'b0, ~d, 4'd0);
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_valid%0d", tag, i), {31'd0, out_valid}, 32'd1);
            checkOutput($sformatf("%s_bit%0d", tag, i), {31'd0, out}, {31'd0, bits[n-1-i]});
            checkOutput($sformatf("%s_busy%0d", tag, i), {31'd0, busy}, 32'd1);
            checkOutput($sformatf("%s_done%0d", tag, i), {31'd0, done}, 32'd0);
            if (i == n - 1) begin
                checkOutput({tag, "_cnt_last"}, {24'd0, pat_cnt}, {24'd0, cnt});
            end
            tick();
        end
        checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
        checkOutput({tag, "_done_busy"}, {31'd0, busy}, 32'd1);
        checkOutput({tag, "_done_valid"}, {31'd0, out_valid}, 32'd0);
        checkOutput({tag, "_done_out"}, {31'd0, out}, 32'd0);
        checkOutput({tag, "_done_cnt"}, {24'd0, pat_cnt}, {24'd0, cnt});
        tick();
        checkIdle({tag, "_idle"}, cnt);
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b1, 8'h66, 4'd8);
        tick();
        tick();
        checkIdle("reset_hold", 8'd0);
        applyStimulus(1'b0, 8'h00, 4'd0);
        #3 rst_n = 1'b1;
        tick();
        checkIdle("after_reset", 8'd0);

        runFrame("f66", 8'h66, 4'd8, 8'h66, 8, 8'd2);
        runFrame("f3", 8'hF3, 4'd3, 8'b011, 3, 8'd1);
        runFrame("clamp", 8'hFF, 4'd15, 8'hFF, 8, 8'd0);
        runFrame("len0", 8'hFF, 4'd0, 8'h00, 0, 8'd0);

        // Start held high: frames every len+2 cycles, data change mid-frame ignored.
        applyStimulus(1'b1, 8'h01, 4'd2);
        tick();
        checkOutput("b2b_f1_b0", {30'd0, out_valid, out}, 32'b10);
        data_in = 8'h00;
        tick();
        checkOutput("b2b_f1_b1", {30'd0, out_valid, out}, 32'b11);
        tick();
        checkOutput("b2b_f1_done", {30'd0, done, busy}, 32'b11);
        tick();
        checkOutput("b2b_gap", {29'd0, busy, done, out_valid}, 32'd0);
        data_in = 8'h01;
        tick();
        checkOutput("b2b_f2_b0", {30'd0, out_valid, out}, 32'b10);
        tick();
        checkOutput("b2b_f2_b1", {30'd0, out_valid, out}, 32'b11);
        tick();
        checkOutput("b2b_f2_done", {30'd0, done, busy}, 32'b11);
        applyStimulus(1'b0, 8'h00, 4'd0);
        tick();
        checkIdle("b2b_end", 8'd0);

        // Abort mid-frame with an asynchronous reset between edges.
        applyStimulus(1'b1, 8'h66, 4'd8);
        tick();
        applyStimulus(1'b0, 8'h00, 4'd0);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("abort_busy_before", {31'd0, busy}, 32'd1);
        checkOutput("abort_cnt_before", {24'd0, pat_cnt}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkIdle("async_reset", 8'd0);
        tick();
        #2 rst_n = 1'b1;
        tick();
        checkIdle("post_abort", 8'd0);
        runFrame("clean", 8'h03, 4'd3, 8'b011, 3, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
